stepper_phase_controller: RTL and testbench

- Sequences a 4-coil stepper driver through one-hot/two-hot phase patterns generated from a 3-bit rotating phase index.
- Accepts a move command: direction, full/half-step mode, step count and step period.
- Issues exactly the commanded number of steps at the programmed rate, then pulses done.
- Sits between a command source (CPU register block or test FSM) and the coil driver outputs.

---
 rtl/stepper_pkg.sv | 19 +
 rtl/step_rate_divider.sv | 35 +++
 rtl/stepper_phase_controller.sv | 141 ++++++++++++++
 tb/tb_stepper_phase_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared state encoding, coil phase table and index step sizes
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Entry 0 sits in the least significant nibble.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    localparam logic [2:0] IDX_STEP_HALF = 3'd1;
    localparam logic [2:0] IDX_STEP_FULL = 3'd2;

endpackage

// File: rtl/step_rate_divider.sv
// rtl/step_rate_divider.sv - loadable down-counter; tick is high while the count is zero
module step_rate_divider #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] load_value,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count_q;
    logic [DIV_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == '0);

endmodule

// File: rtl/stepper_phase_controller.sv
// rtl/stepper_phase_controller.sv - move sequencer driving 4-coil phase patterns from a rotating index
module stepper_phase_controller
    import stepper_pkg::*;
#(
    parameter int STEP_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic                  half_step,
    input  logic [STEP_WIDTH-1:0] steps,
    input  logic [DIV_WIDTH-1:0]  period,
    input  logic                  abort,
    input  logic                  hold,
    output logic [3:0]            phase,
    output logic                  busy,
    output logic                  done,
    output logic [STEP_WIDTH-1:0] remaining
);

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic                  dir_q, dir_d;
    logic                  half_q, half_d;
    logic [DIV_WIDTH-1:0]  period_q, period_d;
    logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
    logic [3:0]            phase_q, phase_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  div_load;
    logic [DIV_WIDTH-1:0]  div_load_value;
    logic                  div_tick;
    logic [2:0]            idx_step;

    step_rate_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_divider (
        .clk        (clk),
        .rst        (rst),
        .load       (div_load),
        .en         (state_q == ST_RUN),
        .load_value (div_load_value),
        .tick       (div_tick)
    );

    assign idx_step = half_q ? IDX_STEP_HALF : IDX_STEP_FULL;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        dir_d          = dir_q;
        half_d         = half_q;
        period_d       = period_q;
        remaining_d    = remaining_q;
        div_load       = 1'b0;
        div_load_value = period_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (steps != '0) begin
                        dir_d          = dir;
                        half_d         = half_step;
                        period_d       = period;
                        remaining_d    = steps;
                        div_load       = 1'b1;
                        div_load_value = period;
                        // Full-step runs on odd indices (two-hot patterns); aligning is not a step.
                        if (!half_step) begin
                            idx_d = idx_q | 3'd1;
                        end
                        state_d = ST_RUN;
                    end else begin
                        remaining_d = steps;
                        state_d     = ST_FINISH;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (div_tick) begin
                    idx_d       = dir_q ? (idx_q + idx_step) : (idx_q - idx_step);
                    remaining_d = remaining_q - 1'b1;
                    div_load    = 1'b1;
                    if (remaining_q == STEP_WIDTH'(1)) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_FINISH);
        // Coils stay driven through the edge that ends a move so the last step is visible in FINISH.
        if ((state_q == ST_RUN) || (state_d == ST_RUN) || hold) begin
            phase_d = PHASE_TABLE[idx_d];
        end else begin
            phase_d = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            dir_q       <= 1'b0;
            half_q      <= 1'b0;
            period_q    <= '0;
            remaining_q <= '0;
            phase_q     <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dir_q       <= dir_d;
            half_q      <= half_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign phase     = phase_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_stepper_phase_controller.sv
// tb/tb_stepper_phase_controller.sv - randomized self-checking bench for stepper_phase_controller
module tb_stepper_phase_controller;

    localparam logic [3:0] TBL [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                       4'b0100, 4'b1100, 4'b1000, 4'b1001};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic        half_step;
    logic [7:0]  steps;
    logic [15:0] period;
    logic        abort;
    logic        hold;
    logic [3:0]  phase;
    logic        busy;
    logic        done;
    logic [7:0]  remaining;

    int checks = 0;
    int errors = 0;
    int m_idx  = 0;

    always #5 clk = ~clk;

    stepper_phase_controller dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .half_step (half_step),
        .steps     (steps),
        .period    (period),
        .abort     (abort),
        .hold      (hold),
        .phase     (phase),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    function automatic int wrap8(input int x);
        return ((x % 8) + 8) % 8;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one move from IDLE and compares every cycle against the arithmetic model:
    // after c cycles of RUN, floor((c-1)/(p+1)) steps have been taken.
    task automatic run_move(input string name, input bit d, input bit h, input int n,
                            input int p, input bit hd, input int abort_at);
        int total, taken, step_sz, sgn, e_idx, stop_c;
        bit aborted;
        step_sz = h ? 1 : 2;
        sgn     = d ? 1 : -1;
        if (!h) m_idx = m_idx | 1;
        total   = n * (p + 1);
        stop_c  = total;
        aborted = 1'b0;
        start = 1'b1; dir = d; half_step = h; steps = 8'(n); period = 16'(p); hold = hd;
        tick();
        start = 1'b0; dir = 1'($urandom); half_step = 1'($urandom);
        steps = 8'($urandom); period = 16'($urandom_range(0, 7));
        for (int c = 1; c <= total; c++) begin
            taken = (c - 1) / (p + 1);
            e_idx = wrap8(m_idx + sgn * step_sz * taken);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || remaining !== 8'(n - taken) || phase !== TBL[e_idx]) begin
                errors++;
                $display("FAIL %s run c=%0d: busy=%b done=%b rem=%0d phase=%b, required busy=1 done=0 rem=%0d phase=%b",
                         name, c, busy, done, remaining, phase, n - taken, TBL[e_idx]);
            end
            if (c == abort_at) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; steps = 8'($urandom); period = 16'($urandom_range(0, 7));
            end
            tick();
            abort = 1'b0;
            start = 1'b0;
            if (aborted) begin
                stop_c = c;
                break;
            end
        end
        taken = aborted ? (stop_c - 1) / (p + 1) : n;
        m_idx = wrap8(m_idx + sgn * step_sz * taken);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || remaining !== 8'(n - taken) || phase !== TBL[m_idx]) begin
            errors++;
            $display("FAIL %s finish: busy=%b done=%b rem=%0d phase=%b, required busy=0 done=1 rem=%0d phase=%b",
                     name, busy, done, remaining, phase, n - taken, TBL[m_idx]);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || remaining !== 8'(n - taken) ||
            phase !== (hd ? TBL[m_idx] : 4'b0000)) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b rem=%0d phase=%b, required busy=0 done=0 rem=%0d phase=%b",
                     name, busy, done, remaining, phase, n - taken, hd ? TBL[m_idx] : 4'b0000);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; dir = 1'b0; half_step = 1'b0; steps = '0;
        period = '0; abort = 1'b0; hold = 1'b0;
        tick();
        tick();
        checks++;
        if (phase !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || remaining !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: phase=%b busy=%b done=%b rem=%0d, required 0000 0 0 0",
                     phase, busy, done, remaining);
        end
        rst = 1'b1;
        hold = 1'b1;
        tick();
        checks++;
        if (phase !== 4'b0001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: phase=%b busy=%b, required phase=0001 busy=0", phase, busy);
        end
        m_idx = 0;
    endtask

    task automatic test_forward_half();
        hold = 1'b0;
        tick();
        run_move("fwd_half", 1'b1, 1'b1, 3, 1, 1'b0, 0);
    endtask

    task automatic test_ignored_start_async_reset();
        start = 1'b1; dir = 1'b1; half_step = 1'b1; steps = 8'd6; period = 16'd2; hold = 1'b0;
        tick();
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (busy !== 1'b1 || remaining !== 8'(6 - (c - 1) / 3)) begin
                errors++;
                $display("FAIL ignored_start c=%0d: busy=%b rem=%0d, required busy=1 rem=%0d",
                         c, busy, remaining, 6 - (c - 1) / 3);
            end
            start = 1'b1; steps = 8'd1; period = 16'd0; dir = 1'b0;
            tick();
            start = 1'b0;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (phase !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || remaining !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: phase=%b busy=%b done=%b rem=%0d, required 0000 0 0 0",
                     phase, busy, done, remaining);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_no_done: done=%b busy=%b, required 0 0", done, busy);
        end
        rst = 1'b1;
        m_idx = 0;
        tick();
    endtask

    task automatic test_reverse_full();
        run_move("rev_full", 1'b0, 1'b0, 5, 0, 1'b1, 0);
        tick();
        checks++;
        if (phase !== 4'b1001 || m_idx != 7) begin
            errors++;
            $display("FAIL rev_full_hold: phase=%b model_idx=%0d, required phase=1001 idx=7", phase, m_idx);
        end
    endtask

    task automatic test_zero_steps();
        start = 1'b1; steps = 8'd0; period = 16'd4; hold = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || phase !== TBL[m_idx]) begin
            errors++;
            $display("FAIL zero_steps_finish: busy=%b done=%b phase=%b, required busy=0 done=1 phase=%b",
                     busy, done, phase, TBL[m_idx]);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || phase !== TBL[m_idx]) begin
            errors++;
            $display("FAIL zero_steps_idle: busy=%b done=%b phase=%b, required busy=0 done=0 phase=%b",
                     busy, done, phase, TBL[m_idx]);
        end
    endtask

    task automatic test_abort();
        run_move("abort", 1'b1, 1'b1, 10, 3, 1'b1, 12);
        run_move("after_abort", 1'b0, 1'b0, 2, 1, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int n, p, ab;
        for (int k = 0; k < 10; k++) begin
            n  = int'($urandom_range(1, 6));
            p  = int'($urandom_range(0, 3));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n * (p + 1))) : 0;
            run_move($sformatf("b2b%0d", k), 1'($urandom), 1'($urandom), n, p, 1'($urandom), ab);
        end
    endtask

    initial begin
        test_reset();
        test_forward_half();
        test_ignored_start_async_reset();
        test_reverse_full();
        test_zero_steps();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
